// File: rtl/send_packet_from_mem.sv
// send_packet_from_mem: GMII transmitter framing length-FIFO packets from memory (preamble, SFD, data, IFG; 4-byte CRC-32 FCS when TX_FCS_EN is defined)
module send_packet_from_mem #(
  parameter int pMEM_WIDTH = 11,
  parameter int pLEN_WIDTH = 16,
  parameter int pIFG = 12
) (
  input  logic                  iclk,
  input  logic                  i_rst,
  input  logic                  iempty,
  input  logic [pLEN_WIDTH-1:0] ilen_pac,
  output logic                  ord_len,
  output logic [pMEM_WIDTH-1:0] or_addr,
  input  logic [7:0]            ir_data,
  output logic                  otx_en,
  output logic [7:0]            otx_d,
  output logic                  otx_er,
  output logic                  obusy,
  output logic                  odone
);
  typedef enum logic [2:0] {
    IDLE, POP, PRE, SFD, DATA,
`ifdef TX_FCS_EN
    FCS,
`endif
    IFG
  } state_t;
  state_t state, state_n;
  logic [pLEN_WIDTH-1:0] cnt, len;
  logic [pMEM_WIDTH-1:0] ptr;
  logic last;
`ifdef TX_FCS_EN
  logic [31:0] crc, fcs;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
  assign fcs = ~crc;
`endif
  assign otx_er = 1'b0;
  assign obusy = state != IDLE;
  assign or_addr = (state == DATA) ? ptr + pMEM_WIDTH'(1) : ptr;
  always_comb begin
    state_n = state;
    last = 1'b0;
    ord_len = 1'b0;
    otx_en = 1'b0;
    otx_d = 8'h00;
    odone = 1'b0;
    case (state)
      IDLE: begin
        ord_len = !iempty && !i_rst;
        state_n = iempty ? IDLE : POP;
      end
      POP: state_n = (len == '0) ? IDLE : PRE;
      PRE: begin
        otx_en = 1'b1;
        otx_d = 8'h55;
        last = cnt == pLEN_WIDTH'(6);
        state_n = last ? SFD : PRE;
      end
      SFD: begin
        otx_en = 1'b1;
        otx_d = 8'hD5;
        state_n = DATA;
      end
      DATA: begin
        otx_en = 1'b1;
        otx_d = ir_data;
        last = cnt == len - pLEN_WIDTH'(1);
`ifdef TX_FCS_EN
        state_n = last ? FCS : DATA;
`else
        state_n = last ? IFG : DATA;
        odone = last;
`endif
      end
`ifdef TX_FCS_EN
      FCS: begin
        otx_en = 1'b1;
        otx_d = fcs[{cnt[1:0], 3'b000} +: 8];
        last = cnt[1:0] == 2'd3;
        state_n = last ? IFG : FCS;
        odone = last;
      end
`endif
      IFG: begin
        last = cnt == pLEN_WIDTH'(pIFG - 1);
        state_n = last ? IDLE : IFG;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      ptr <= '0;
`ifdef TX_FCS_EN
      crc <= '1;
`endif
    end else begin
      state <= state_n;
      cnt <= (state_n != state || state == IDLE) ? '0 : cnt + pLEN_WIDTH'(1);
      if (ord_len) len <= ilen_pac;
      if (state == DATA) ptr <= ptr + pMEM_WIDTH'(1);
`ifdef TX_FCS_EN
      crc <= (state == SFD) ? '1 : (state == DATA) ? crc_byte(crc, ir_data) : crc;
`endif
    end
  end
endmodule

// File: tb/tb_send_packet_from_mem.sv
// tb_send_packet_from_mem: scoreboard bench for send_packet_from_mem with a 64-byte memory (pMEM_WIDTH=6)
module tb_send_packet_from_mem;
  localparam int MW = 6;
`ifdef TX_FCS_EN
  localparam int FCSB = 4;
`else
  localparam int FCSB = 0;
`endif
  typedef struct packed {logic [7:0] d; logic done;} exp_t;
  logic clk = 1'b0;
  logic i_rst, iempty, ord_len, otx_en, otx_er, obusy, odone;
  logic [15:0] ilen_pac;
  logic [MW-1:0] or_addr;
  logic [7:0] ir_data, otx_d;
  logic [7:0] mem [0:63];
  logic [15:0] fifo [0:15];
  int wp = 0, rp = 0, mptr = 0;
  int n_cmp = 0, n_bad = 0;
  int en_pos = 0, en_run = 0, ifg_cnt = 0, ifg_len = 0, done_cnt = 0;
  logic in_ifg = 1'b0;
  exp_t sb[$];
  exp_t e_m;
  send_packet_from_mem #(.pMEM_WIDTH(MW), .pLEN_WIDTH(16), .pIFG(12)) dut (
    .iclk(clk), .i_rst(i_rst), .iempty(iempty), .ilen_pac(ilen_pac), .ord_len(ord_len),
    .or_addr(or_addr), .ir_data(ir_data), .otx_en(otx_en), .otx_d(otx_d), .otx_er(otx_er),
    .obusy(obusy), .odone(odone)
  );
  always #5 clk = ~clk;
  assign iempty = wp == rp;
  assign ilen_pac = fifo[rp[3:0]];
  always @(posedge clk) begin
    ir_data <= mem[or_addr];
    if (ord_len) rp <= rp + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] d, input logic done);
    exp_t x;
    x.d = d;
    x.done = done;
    sb.push_back(x);
  endtask
  task automatic queue_pkt(input int len);
    logic [31:0] c;
    logic [7:0] b;
    fifo[wp[3:0]] = 16'(len);
    wp++;
    if (len == 0) return;
    repeat (7) push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      b = mem[mptr];
      push(b, (FCSB == 0) && (i == len - 1));
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      mptr = (mptr + 1) % 64;
    end
`ifdef TX_FCS_EN
    c = ~c;
    for (int i = 0; i < 4; i++) push(c[8*i +: 8], i == 3);
`endif
  endtask
  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((sb.size() != 0 || obusy || !iempty) && k < 3000);
    check("frame_complete", {31'h0, sb.size() == 0 && !obusy}, 32'h1);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    mptr = 0;
  endtask
  always begin
    @(posedge clk);
    #1;
    check("otx_er", {31'h0, otx_er}, 32'h0);
    if (otx_en) begin
      if (sb.size() == 0) check("unexpected_byte", {31'h0, otx_en}, 32'h0);
      else begin
        e_m = sb.pop_front();
        check("otx_d", {24'h0, otx_d}, {24'h0, e_m.d});
        check("odone", {31'h0, odone}, {31'h0, e_m.done});
      end
      en_pos++;
    end else begin
      check("idle_d", {24'h0, otx_d}, 32'h0);
      check("idle_done", {31'h0, odone}, 32'h0);
      if (en_pos != 0) en_run = en_pos;
      en_pos = 0;
    end
    if (odone) begin
      done_cnt++;
      in_ifg = 1'b1;
      ifg_cnt = 0;
    end else if (in_ifg) begin
      if (obusy) ifg_cnt++;
      else begin
        in_ifg = 1'b0;
        ifg_len = ifg_cnt;
      end
    end
  end
  initial begin
    int k;
    i_rst = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    check("rst_en", {31'h0, otx_en}, 32'h0);
    check("rst_d", {24'h0, otx_d}, 32'h0);
    check("rst_busy", {31'h0, obusy}, 32'h0);
    check("rst_addr", {26'h0, or_addr}, 32'h0);
    check("rst_pop", {31'h0, ord_len}, 32'h0);
    i_rst = 1'b0;
    repeat (50) begin
      @(negedge clk);
      check("idle_en", {31'h0, otx_en}, 32'h0);
      check("idle_pop", {31'h0, ord_len}, 32'h0);
      check("idle_addr", {26'h0, or_addr}, 32'h0);
    end
    queue_pkt(60);
    wait_idle();
    check("en_cycles_60", en_run, 68 + FCSB);
    check("ifg_60", ifg_len, 12);
    check("pops_60", rp, 1);
    pulse_reset();
    queue_pkt(0);
    queue_pkt(64);
    wait_idle();
    check("en_cycles_64", en_run, 72 + FCSB);
    check("pops_0_64", rp, 3);
    pulse_reset();
    queue_pkt(40);
    queue_pkt(40);
    wait_idle();
    check("en_cycles_wrap", en_run, 48 + FCSB);
    check("pops_wrap", rp, 5);
    queue_pkt(60);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (en_pos != 28 && k < 500);
    check("reach_byte20", en_pos, 28);
    i_rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_en", {31'h0, otx_en}, 32'h0);
    check("abort_addr", {26'h0, or_addr}, 32'h0);
    check("abort_busy", {31'h0, obusy}, 32'h0);
    i_rst = 1'b0;
    mptr = 0;
    queue_pkt(30);
    wait_idle();
    check("en_cycles_after_abort", en_run, 38 + FCSB);
    check("done_count", done_cnt, 5);
    check("pops_total", rp, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
